// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small circular byte FIFO.
// Frames run back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [BW-1:0] baud;
    logic          bit_end;
    logic          push;
    logic          pop;

    assign bit_end    = (baud == BW'(CLKS_PER_BIT - 1));
    assign data_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = data_valid & data_ready;
    assign pop        = (count != '0) &&
                        ((state == IDLE) || ((state == STOP) && bit_end));
    assign fifo_count = count;
    assign busy       = (state != IDLE);

    // Storage needs no reset: pointer reset discards the contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default instance plus a
// CLKS_PER_BIT=2 / FIFO_DEPTH=2 instance, decoded at mid-bit.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       va, vb;
    logic       rdy_a, tx_a, busy_a;
    logic [2:0] cnt_a;
    logic       rdy_b, tx_b, busy_b;
    logic [1:0] cnt_b;
    logic       tx_s, rdy_s, busy_s;
    logic [2:0] cnt_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] src [8];
    logic [7:0] got [8];
    logic       okr [8];
    int         ts  [8];

    assign va     = dv & ~sel;
    assign vb     = dv & sel;
    assign tx_s   = sel ? tx_b : tx_a;
    assign rdy_s  = sel ? rdy_b : rdy_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign cnt_s  = sel ? {1'b0, cnt_b} : cnt_a;

    uart_tx_fifo dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_valid(va), .data_ready(rdy_a), .tx(tx_a),
        .busy(busy_a), .fifo_count(cnt_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_valid(vb), .data_ready(rdy_b), .tx(tx_b),
        .busy(busy_b), .fifo_count(cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Push src[0..n-1] holding data_valid; a byte advances only on ready.
    task automatic hold_push(input int n, output logic ok);
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < n && guard < 2000) begin
            data_in = src[i];
            dv = 1'b1;
            acc = rdy_s;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        dv = 1'b0;
        ok = (i == n);
    endtask

    task automatic recv(input int cpb, output logic [7:0] b,
                        output logic ok, output int t);
        logic found = 1'b0;
        ok = 1'b0;
        b = 8'h00;
        t = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (tx_s === 1'b0) found = 1'b1;
        end
        if (!found) return;
        t = cyc;
        repeat (cpb / 2) @(negedge clk);
        if (tx_s !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (cpb) @(negedge clk);
            b[k] = tx_s;
        end
        repeat (cpb) @(negedge clk);
        ok = (tx_s === 1'b1);
    endtask

    task automatic recv_n(input int cpb, input int n);
        for (int j = 0; j < n; j++)
            recv(cpb, got[j], okr[j], ts[j]);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b1 || cnt_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_a: tx=%b busy=%b rdy=%b cnt=%0d, need 1 0 1 0",
                     tx_a, busy_a, rdy_a, cnt_a);
        end
        checks++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || rdy_b !== 1'b1 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_b: tx=%b busy=%b rdy=%b cnt=%0d, need 1 0 1 0",
                     tx_b, busy_b, rdy_b, cnt_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic ok;
        logic [7:0] b;
        int c_acc, t;
        repeat (20) @(negedge clk);
        src[0] = 8'hA5;
        hold_push(1, ok);
        c_acc = cyc;
        checks++;
        if (cnt_s !== 3'd1 || tx_s !== 1'b1) begin
            errors++;
            $display("FAIL single_queued: cnt=%0d tx=%b, need 1 1", cnt_s, tx_s);
        end
        recv(10, b, ok, t);
        checks++;
        if (t !== c_acc + 1) begin
            errors++;
            $display("FAIL single_fall: fell at cycle %0d, need %0d", t, c_acc + 1);
        end
        checks++;
        if (!ok || b !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: got %h ok=%b, need a5 ok=1", b, ok);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL single_busy99: busy=%b, need 1", busy_s);
        end
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || tx_s !== 1'b1) begin
            errors++;
            $display("FAIL single_busy100: busy=%b tx=%b, need 0 1", busy_s, tx_s);
        end
    endtask

    task automatic test_back_to_back;
        logic ok;
        repeat (20) @(negedge clk);
        src[0] = 8'h00; src[1] = 8'hFF; src[2] = 8'h55;
        fork
            hold_push(3, ok);
            recv_n(10, 3);
        join
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (!okr[j] || got[j] !== src[j]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h ok=%b, need %h", j, got[j], okr[j], src[j]);
            end
        end
        for (int j = 1; j < 3; j++) begin
            checks++;
            if (ts[j] - ts[j-1] !== 100) begin
                errors++;
                $display("FAIL b2b_gap%0d: period %0d, need 100", j, ts[j] - ts[j-1]);
            end
        end
    endtask

    task automatic test_full;
        repeat (20) @(negedge clk);
        src[0] = 8'h11; src[1] = 8'h12; src[2] = 8'h34;
        src[3] = 8'h56; src[4] = 8'h78; src[5] = 8'h9A;
        fork
            begin
                int i = 0;
                int g = 0;
                logic acc;
                while (i < 5 && g < 50) begin
                    data_in = src[i];
                    dv = 1'b1;
                    acc = rdy_s;
                    @(negedge clk);
                    if (acc) i++;
                    g++;
                end
                checks++;
                if (cnt_s !== 3'd4 || rdy_s !== 1'b0) begin
                    errors++;
                    $display("FAIL full_state: cnt=%0d rdy=%b, need 4 0", cnt_s, rdy_s);
                end
                data_in = src[5];
                g = 0;
                while (!rdy_s && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                checks++;
                if (rdy_s !== 1'b1 || cnt_s !== 3'd3) begin
                    errors++;
                    $display("FAIL full_pop: rdy=%b cnt=%0d, need 1 3", rdy_s, cnt_s);
                end
                @(negedge clk);
                dv = 1'b0;
                data_in = 8'hEE;
                checks++;
                if (cnt_s !== 3'd4) begin
                    errors++;
                    $display("FAIL full_accept5: cnt=%0d, need 4", cnt_s);
                end
            end
            recv_n(10, 6);
        join
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (!okr[j] || got[j] !== src[j]) begin
                errors++;
                $display("FAIL full_byte%0d: got %h ok=%b, need %h", j, got[j], okr[j], src[j]);
            end
        end
    endtask

    task automatic test_push_pop;
        repeat (20) @(negedge clk);
        src[0] = 8'h3C; src[1] = 8'hC3; src[2] = 8'h96;
        fork
            begin
                data_in = src[0]; dv = 1'b1;
                @(negedge clk);
                data_in = src[1];
                @(negedge clk);
                dv = 1'b0;
                repeat (99) @(negedge clk);
                checks++;
                if (cnt_s !== 3'd1) begin
                    errors++;
                    $display("FAIL pp_before: cnt=%0d, need 1", cnt_s);
                end
                data_in = src[2]; dv = 1'b1;
                @(negedge clk);
                dv = 1'b0;
                checks++;
                if (cnt_s !== 3'd1 || tx_s !== 1'b0) begin
                    errors++;
                    $display("FAIL pp_after: cnt=%0d tx=%b, need 1 0", cnt_s, tx_s);
                end
            end
            recv_n(10, 3);
        join
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (!okr[j] || got[j] !== src[j]) begin
                errors++;
                $display("FAIL pp_byte%0d: got %h ok=%b, need %h", j, got[j], okr[j], src[j]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lows = 0;
        repeat (20) @(negedge clk);
        data_in = 8'h0F; dv = 1'b1;
        @(negedge clk);
        data_in = 8'h01;
        @(negedge clk);
        data_in = 8'h02;
        @(negedge clk);
        dv = 1'b0;
        repeat (43) @(negedge clk);
        checks++;
        if (tx_s !== 1'b1 || cnt_s !== 3'd2 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL rst_bit3: tx=%b cnt=%0d busy=%b, need 1 2 1", tx_s, cnt_s, busy_s);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_s !== 1'b1 || cnt_s !== 3'd0 || busy_s !== 1'b0 || rdy_s !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: tx=%b cnt=%0d busy=%b rdy=%b, need 1 0 0 1",
                     tx_s, cnt_s, busy_s, rdy_s);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_s !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0 || cnt_s !== 3'd0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: low cycles=%0d cnt=%0d busy=%b, need 0 0 0",
                     lows, cnt_s, busy_s);
        end
    endtask

    task automatic test_small;
        logic ok;
        logic [7:0] b;
        int t;
        sel = 1'b1;
        repeat (10) @(negedge clk);
        src[0] = 8'h81;
        hold_push(1, ok);
        recv(2, b, ok, t);
        checks++;
        if (!ok || b !== 8'h81) begin
            errors++;
            $display("FAIL small_byte: got %h ok=%b, need 81", b, ok);
        end
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL small_busy19: busy=%b, need 1", busy_s);
        end
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0) begin
            errors++;
            $display("FAIL small_busy20: busy=%b, need 0", busy_s);
        end
        repeat (5) @(negedge clk);
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h04;
        src[3] = 8'h08; src[4] = 8'h10; src[5] = 8'h20;
        fork
            hold_push(6, ok);
            recv_n(2, 6);
        join
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL small_push: accepted=%b, need 1", ok);
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (!okr[j] || got[j] !== src[j]) begin
                errors++;
                $display("FAIL small_byte%0d: got %h ok=%b, need %h", j, got[j], okr[j], src[j]);
            end
        end
        for (int j = 1; j < 6; j++) begin
            checks++;
            if (ts[j] - ts[j-1] !== 20) begin
                errors++;
                $display("FAIL small_gap%0d: period %0d, need 20", j, ts[j] - ts[j-1]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_push_pop;
        test_reset_mid;
        test_small;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter (8N1, LSB first) with a small input FIFO. It serializes result bytes, such as oscillator counts and temperature status, onto the chip's tx pin (uo_out[0]). It is the transmit-side counterpart of the existing UART receive path and runs on the system clock `clk`. Default timing gives 1000 baud from a 10 kHz clk, matching the system-level bench bit time of 1 ms.

Parameters:
CLKS_PER_BIT, 10, clk cycles per UART bit; must be >= 2.
FIFO_DEPTH, 4, number of byte entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  8  byte to transmit.
data_valid  input  1  producer strobe; a byte is accepted on a rising edge where data_valid=1 and data_ready=1.
data_ready  output  1  FIFO not full (= !full, registered state).
tx  output  1  serial line, registered, idle high.
busy  output  1  high while a frame is in progress (state != IDLE).
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries currently stored.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: tx=1, busy=0, data_ready=1, fifo_count=0.
  - Internals: FIFO pointers=0, state=IDLE, bit counter=0, baud counter=0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high with no glitch low. All FIFO contents are discarded.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push when data_valid & data_ready.
  - Pop when the FSM loads a byte.
  - Simultaneous push and pop: fifo_count unchanged, both accepted.
  - Push while full: impossible, because data_ready=0 and data_valid is ignored. Data held under data_valid while full is neither dropped nor corrupted; it is accepted on the first edge with data_ready=1.
  - No bypass: a byte pushed into an empty FIFO is popped on the following edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0: pop into shift register, tx<=0, baud counter<=0, go to START. tx falls exactly 1 cycle after the accepting edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles. Then tx<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, sent LSB first. After bit index 7 completes: tx<=1, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end:
    - if fifo_count>0: pop, tx<=0, go to START (back-to-back frames, no idle gap);
    - else go to IDLE.
- Timing and arithmetic:
  - Frame length is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index counts 0..7.
  - No parity bit; a single stop bit.
- busy: high from the cycle tx falls until the end of the last stop bit with an empty FIFO.
- data_ready and fifo_count always reflect the current registered state. A pop frees a slot visible on the next cycle.
- data_in is sampled only at the accepting edge. Later changes to data_in do not affect queued or in-flight bytes.

Test Plan:
1. Reset → tx=1, busy=0, data_ready=1, fifo_count=0. Push 0xA5 → tx falls 1 cycle later. Bits sampled at mid-bit (every 10 cycles) read 0,1,0,1,0,0,1,0,1 and then stop=1, i.e. the start bit followed by 0xA5 LSB first. busy deasserts after 100 cycles.
2. Push 0x00, 0xFF, 0x55 on consecutive cycles → three frames totalling 300 cycles with no idle gap between stop and the next start. Decoded bytes are 0x00, 0xFF, 0x55 in order.
3. Full FIFO:
   - Hold data_valid high while a frame is active and push 5 bytes → data_ready=0 once fifo_count=4.
   - The 5th byte is accepted on the edge after the next pop.
   - All 5 bytes are transmitted in order with none lost.
4. Simultaneous push and pop: push on the exact cycle STOP pops the next entry → fifo_count unchanged and both bytes are sent correctly.
5. Reset mid-frame: assert rst_n=0 during bit 3 of 0x0F with 2 bytes queued → tx=1 immediately, fifo_count=0. After release, tx stays high and no frame is sent.
6. CLKS_PER_BIT=2 and FIFO_DEPTH=2 instance: push 0x81 → 20-cycle frame decodes to 0x81. The pointers wrap correctly across 6 pushes.
